// File: rtl/w5300_receiver.sv
// w5300_receiver: per-socket receive engine for the W5300 Ethernet controller.
// On eth_rx_req it reads socket N's received-size registers. If data is
// pending, it reads the PACKET-INFO length word, drains the payload from
// Sn_RX_FIFOR into the local RX buffer, and then issues the RECV command.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   eth_rx_req          - start one poll/receive pass (sampled in Idle only)
//   eth_rx_buffer_addr  - RX buffer word write address
//   eth_rx_buffer_data  - RX buffer write data
//   eth_rx_buffer_wr    - RX buffer write strobe (one word per high cycle)
//   rx_len              - byte length of the last packet (0 if none pending)
//   rx_overflow         - last packet exceeded RX buffer capacity
//   rx_done             - single-cycle pulse at the end of each pass
//   addr, wr_data       - register bus request {RD/WR, reg} and write data
//   rd_data, op_state   - register read data and operation-complete pulse
module w5300_receiver #(
    parameter logic [2:0]  N                   = 3'd0,
    parameter int unsigned ETH_RX_BUFFER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eth_rx_req,
    output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
    output logic [15:0]                    eth_rx_buffer_data,
    output logic                           eth_rx_buffer_wr,
    output logic [15:0]                    rx_len,
    output logic                           rx_overflow,
    output logic                           rx_done,
    output logic [9:0]                     addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state
);

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Socket register word offsets (socket block at word 0x100, 0x20 words per socket).
    localparam logic [8:0] SN_CR_OFS        = 9'h001;
    localparam logic [8:0] SN_RX_RSR0_OFS   = 9'h014;
    localparam logic [8:0] SN_RX_RSR2_OFS   = 9'h015;
    localparam logic [8:0] SN_RX_FIFOR_OFS  = 9'h018;
    localparam logic [15:0] SN_CR_RECV      = 16'h0040;

    function automatic logic [8:0] get_socket_n_reg(input logic [2:0] n, input logic [8:0] ofs);
        return 9'h100 + {1'b0, n, 5'b0_0000} + ofs;
    endfunction

    localparam logic [8:0] REG_RSR0  = get_socket_n_reg(N, SN_RX_RSR0_OFS);
    localparam logic [8:0] REG_RSR2  = get_socket_n_reg(N, SN_RX_RSR2_OFS);
    localparam logic [8:0] REG_FIFOR = get_socket_n_reg(N, SN_RX_FIFOR_OFS);
    localparam logic [8:0] REG_CR    = get_socket_n_reg(N, SN_CR_OFS);

    localparam logic [16:0] BUF_WORDS = 17'(1) << ETH_RX_BUFFER_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_RX_SIZE,
        ST_CHECK_RX_SIZE,
        ST_READ_INFO,
        ST_READ_FIFO_REG,
        ST_DO_RECV,
        ST_FINISH
    } state_t;

    state_t      state, next_state;
    logic        rsr_lo_phase;   // 0: RSR0 (high half) pending, 1: RSR2 (low half)
    logic [31:0] rx_size;
    logic [16:0] word_cnt;
    logic [16:0] rx_words;
    logic [16:0] info_words;

    // Payload word count from the info byte length, rounded up to whole words.
    assign info_words = ({1'b0, rd_data} + 17'd1) >> 1;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        addr       = {RD, 9'h000};
        wr_data    = '0;
        unique case (state)
            ST_IDLE: begin
                if (eth_rx_req) next_state = ST_READ_RX_SIZE;
            end
            ST_READ_RX_SIZE: begin
                addr = {RD, rsr_lo_phase ? REG_RSR2 : REG_RSR0};
                if (op_state && rsr_lo_phase) next_state = ST_CHECK_RX_SIZE;
            end
            ST_CHECK_RX_SIZE: begin
                next_state = (rx_size == 32'd0) ? ST_FINISH : ST_READ_INFO;
            end
            ST_READ_INFO: begin
                addr = {RD, REG_FIFOR};
                if (op_state) next_state = (info_words == 17'd0) ? ST_DO_RECV : ST_READ_FIFO_REG;
            end
            ST_READ_FIFO_REG: begin
                addr = {RD, REG_FIFOR};
                if (op_state && (word_cnt + 17'd1) == rx_words) next_state = ST_DO_RECV;
            end
            ST_DO_RECV: begin
                addr    = {WR, REG_CR};
                wr_data = SN_CR_RECV;
                if (op_state) next_state = ST_FINISH;
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eth_rx_buffer_addr <= '0;
            eth_rx_buffer_data <= '0;
            eth_rx_buffer_wr   <= 1'b0;
            rx_len             <= '0;
            rx_overflow        <= 1'b0;
            rx_done            <= 1'b0;
            rx_size            <= '0;
            word_cnt           <= '0;
            rx_words           <= '0;
            rsr_lo_phase       <= 1'b0;
        end else begin
            eth_rx_buffer_wr <= 1'b0;
            rx_done          <= (next_state == ST_FINISH);
            // The address shown with a write is the write address; it advances
            // once that write has been presented.
            if (eth_rx_buffer_wr)
                eth_rx_buffer_addr <= eth_rx_buffer_addr + ETH_RX_BUFFER_WIDTH'(1);
            unique case (state)
                ST_IDLE: begin
                    if (eth_rx_req) begin
                        rx_size            <= '0;
                        word_cnt           <= '0;
                        eth_rx_buffer_addr <= '0;
                        rsr_lo_phase       <= 1'b0;
                    end
                end
                ST_READ_RX_SIZE: begin
                    if (op_state) begin
                        if (!rsr_lo_phase) rx_size[31:16] <= rd_data;
                        else               rx_size[15:0]  <= rd_data;
                        rsr_lo_phase <= ~rsr_lo_phase;
                    end
                end
                ST_CHECK_RX_SIZE: begin
                    if (rx_size == 32'd0) begin
                        rx_len      <= '0;
                        rx_overflow <= 1'b0;
                    end
                end
                ST_READ_INFO: begin
                    if (op_state) begin
                        rx_len      <= rd_data;
                        rx_words    <= info_words;
                        rx_overflow <= 1'b0;
                    end
                end
                ST_READ_FIFO_REG: begin
                    if (op_state) begin
                        eth_rx_buffer_data <= rd_data;
                        // Words beyond capacity are still drained from the FIFO
                        // to keep the chip's pointers consistent, just not stored.
                        if (word_cnt < BUF_WORDS) eth_rx_buffer_wr <= 1'b1;
                        else                      rx_overflow      <= 1'b1;
                        word_cnt <= word_cnt + 17'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_receiver.sv
module tb_w5300_receiver;

    localparam int W   = 2;
    localparam int CAP = 4;

    localparam logic [9:0] A_IDLE  = 10'h000;
    localparam logic [9:0] A_RSR0  = 10'h114;
    localparam logic [9:0] A_RSR2  = 10'h115;
    localparam logic [9:0] A_FIFOR = 10'h118;
    localparam logic [9:0] A_CR    = 10'h301;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          eth_rx_req = 1'b0;
    logic [W-1:0]  eth_rx_buffer_addr;
    logic [15:0]   eth_rx_buffer_data;
    logic          eth_rx_buffer_wr;
    logic [15:0]   rx_len;
    logic          rx_overflow;
    logic          rx_done;
    logic [9:0]    addr;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data = 16'hDEAD;
    logic          op_state = 1'b0;

    w5300_receiver #(.N(3'd0), .ETH_RX_BUFFER_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .eth_rx_req(eth_rx_req),
        .eth_rx_buffer_addr(eth_rx_buffer_addr), .eth_rx_buffer_data(eth_rx_buffer_data),
        .eth_rx_buffer_wr(eth_rx_buffer_wr), .rx_len(rx_len), .rx_overflow(rx_overflow),
        .rx_done(rx_done), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .op_state(op_state)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [25:0]   exp_ops[$];   // {addr, wr_data}
    logic [W+15:0] exp_wr[$];    // {buffer addr, data}
    logic [15:0]   fifo_q[$];    // FIFOR read responses (info word then payload)
    logic [31:0]   rsr_val = '0;
    int            stall_max = 0;
    int            done_cnt = 0;
    int            wr_cnt = 0;
    logic          done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus controller model: random completion latency, checks request stability.
    bit          busy = 0;
    int          wait_left = 0;
    logic [9:0]  op_addr;
    logic [15:0] op_wd;
    logic [25:0] e_op;
    always @(negedge clk) begin
        op_state = 1'b0;
        rd_data  = 16'hDEAD;
        if (rst) begin
            busy = 0;
        end else begin
            if (busy) begin
                chk("addr_hold", addr, op_addr);
                chk("wdata_hold", wr_data, op_wd);
            end else if (addr != A_IDLE) begin
                busy = 1;
                op_addr = addr;
                op_wd = wr_data;
                wait_left = $urandom_range(0, stall_max);
                chk("op_addr", addr, (exp_ops.size() != 0) ? exp_ops[0][25:16] : A_IDLE);
                if (exp_ops.size() != 0) begin
                    e_op = exp_ops.pop_front();
                    if (addr[9]) chk("op_wdata", wr_data, e_op[15:0]);
                end
            end
            if (busy) begin
                if (wait_left == 0) begin
                    op_state = 1'b1;
                    busy = 0;
                    if (op_addr == A_RSR0)       rd_data = rsr_val[31:16];
                    else if (op_addr == A_RSR2)  rd_data = rsr_val[15:0];
                    else if (op_addr == A_FIFOR) rd_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hBAD0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Output monitor: buffer writes against the scoreboard, rx_done pulse width.
    logic [W+15:0] e_wr;
    always @(negedge clk) begin
        if (eth_rx_buffer_wr) begin
            wr_cnt++;
            if (exp_wr.size() != 0) begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr", eth_rx_buffer_addr, e_wr[W+15:16]);
                chk("wr_data", eth_rx_buffer_data, e_wr[15:0]);
            end else begin
                chk("wr_unexpected", eth_rx_buffer_wr, 1'b0);
            end
        end
        if (rx_done) done_cnt++;
        if (rx_done && done_prev) chk("done_single_cycle", rx_done & done_prev, 1'b0);
        done_prev = rx_done;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, addr, A_IDLE);
        chk({tag, "_wr_data"}, wr_data, 16'h0000);
        chk({tag, "_buf_addr"}, eth_rx_buffer_addr, '0);
        chk({tag, "_buf_data"}, eth_rx_buffer_data, 16'h0000);
        chk({tag, "_buf_wr"}, eth_rx_buffer_wr, 1'b0);
        chk({tag, "_rx_len"}, rx_len, 16'h0000);
        chk({tag, "_rx_overflow"}, rx_overflow, 1'b0);
        chk({tag, "_rx_done"}, rx_done, 1'b0);
    endtask

    task automatic run_pass(input string tag, input logic [31:0] rsr, input logic [15:0] info,
                            input int stall, input bit pattern, input bit extra_req);
        int          nwords;
        int          d0;
        logic [15:0] d;
        logic [15:0] exp_len;
        logic        exp_ovf;
        stall_max = stall;
        rsr_val   = rsr;
        exp_len   = 16'h0000;
        exp_ovf   = 1'b0;
        exp_ops.push_back({A_RSR0, 16'h0000});
        exp_ops.push_back({A_RSR2, 16'h0000});
        if (rsr != 32'd0) begin
            exp_ops.push_back({A_FIFOR, 16'h0000});
            fifo_q.push_back(info);
            nwords = (int'(info) + 1) / 2;
            for (int i = 0; i < nwords; i++) begin
                d = pattern ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
                exp_ops.push_back({A_FIFOR, 16'h0000});
                fifo_q.push_back(d);
                if (i < CAP) exp_wr.push_back({W'(i), d});
            end
            exp_ops.push_back({A_CR, 16'h0040});
            exp_len = info;
            exp_ovf = (nwords > CAP);
        end
        d0 = done_cnt;
        @(posedge clk); #1 eth_rx_req = 1'b1;
        @(posedge clk); #1 eth_rx_req = 1'b0;
        if (extra_req) begin
            repeat (3) @(posedge clk);
            #1 eth_rx_req = 1'b1;
            @(posedge clk); #1 eth_rx_req = 1'b0;
        end
        for (int c = 0; c < 1000 && done_cnt == d0; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_rx_len"}, rx_len, exp_len);
        chk({tag, "_rx_overflow"}, rx_overflow, exp_ovf);
        chk({tag, "_ops_left"}, exp_ops.size(), 0);
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        chk({tag, "_fifo_left"}, fifo_q.size(), 0);
        chk({tag, "_idle_addr"}, addr, A_IDLE);
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        rst = 1'b0;

        run_pass("empty",      32'h0000_0000, 16'h0000, 0, 1'b0, 1'b0);
        run_pass("even",       32'h0000_000A, 16'h0008, 0, 1'b1, 1'b0);
        run_pass("odd",        32'h0000_0006, 16'h0005, 0, 1'b0, 1'b0);
        run_pass("overflow",   32'h0001_0000, 16'h000C, 0, 1'b0, 1'b0);
        run_pass("ovf_clear",  32'h0000_0000, 16'h0000, 0, 1'b0, 1'b0);
        run_pass("zero_info",  32'h0000_0002, 16'h0000, 0, 1'b0, 1'b0);
        run_pass("one_byte",   32'h0000_0004, 16'h0001, 0, 1'b0, 1'b0);
        run_pass("stall_even", 32'h0000_000A, 16'h0008, 5, 1'b1, 1'b1);
        run_pass("stall_odd",  32'h0000_0006, 16'h0005, 5, 1'b0, 1'b1);
        run_pass("stall_ovf",  32'h0000_0010, 16'h000C, 5, 1'b0, 1'b1);
        run_pass("stall_empty",32'h0000_0000, 16'h0000, 5, 1'b0, 1'b0);

        // Reset in the middle of the payload drain: no RECV may follow.
        stall_max = 0;
        rsr_val   = 32'h0000_000A;
        exp_ops.push_back({A_RSR0, 16'h0000});
        exp_ops.push_back({A_RSR2, 16'h0000});
        exp_ops.push_back({A_FIFOR, 16'h0000});
        fifo_q.push_back(16'h0008);
        for (int i = 0; i < 4; i++) begin
            exp_ops.push_back({A_FIFOR, 16'h0000});
            fifo_q.push_back(16'(16'hA0A0 + i));
            exp_wr.push_back({W'(i), 16'(16'hA0A0 + i)});
        end
        w0 = wr_cnt;
        @(posedge clk); #1 eth_rx_req = 1'b1;
        @(posedge clk); #1 eth_rx_req = 1'b0;
        for (int c = 0; c < 200 && wr_cnt < w0 + 2; c++) @(posedge clk);
        #1;
        chk("midrst_writes_seen", (wr_cnt >= w0 + 2), 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        exp_ops.delete();
        exp_wr.delete();
        fifo_q.delete();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_idle_addr", addr, A_IDLE);
        chk("midrst_no_done", rx_done, 1'b0);

        run_pass("after_rst",  32'h0000_000A, 16'h0007, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/w5300_receiver.md
# w5300_receiver

Per-socket receive engine for the W5300 Ethernet controller, the receive counterpart of the socket transmitter. On request it polls socket N's received-size registers. If data is present it reads the PACKET-INFO length word and drains the payload from Sn_RX_FIFOR into a local RX buffer, then issues the RECV command. It shares the W5300 register bus, through the same `addr`/`wr_data`/`rd_data`/`op_state` handshake as the other socket engines, under the bus controller.

## Interface
- `N`, 3'd0, socket index passed to `W5300::get_socket_n_reg` for all register addresses.
- `ETH_RX_BUFFER_WIDTH`, 16, word-address width of the local RX buffer (capacity 2^W 16-bit words).

- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `eth_rx_req` input 1: start one poll/receive pass; sampled only in Idle.
- `eth_rx_buffer_addr` output W: RX buffer word write address.
- `eth_rx_buffer_data` output 16: RX buffer write data.
- `eth_rx_buffer_wr` output 1: RX buffer write strobe, one word per high cycle.
- `rx_len` output 16: byte length of the last packet; 0 if none was pending.
- `rx_overflow` output 1: last packet exceeded buffer capacity.
- `rx_done` output 1: single-cycle pulse at the end of each pass.
- `addr` output 10: `{RD/WR, reg}`. RD=0, WR=1. Idle encoding is `{RD, 9'h000}`.
- `wr_data` output 16: register write data.
- `rd_data` input 16: register read data, valid when `op_state`=1.
- `op_state` input 1: one-cycle pulse when the current bus operation completes.

## Operation
- Registers: RSR0=Sn_RX_RSR0, RSR2=Sn_RX_RSR2, FIFOR=Sn_RX_FIFOR, CR=Sn_CR. Command value is Sn_CR_RECV (8'h40, zero-extended).
- Bus rule: `addr`/`wr_data` are held constant for the whole operation. An operation ends on the cycle `op_state`=1. The next operation's request appears the following cycle.
- States and transitions:
  - **Idle**: outputs idle encoding. On `eth_rx_req`=1, clear the counters and go to ReadRxSize.
  - **ReadRxSize**: read RSR0, then RSR2. Latch `rd_data` into `rx_size[31:16]` and then `rx_size[15:0]`. After the 2nd completion, go to CheckRxSize.
  - **CheckRxSize** (1 cycle): if `rx_size`==0, set `rx_len`=0 and `rx_overflow`=0, then go to Finish. Otherwise go to ReadInfo.
  - **ReadInfo**: one FIFOR read. Latch `rx_len`=`rd_data`. Compute `rx_words`=(`rx_len`+1)>>1 in 17-bit arithmetic. If `rx_words`==0, go to DoRecv; otherwise go to ReadFifoReg.
  - **ReadFifoReg**: repeated FIFOR reads. On each completion:
    - `eth_rx_buffer_data`=`rd_data`.
    - `eth_rx_buffer_wr`=1 only if `word_cnt` < 2^W; otherwise set `rx_overflow`=1 and suppress the write.
    - Increment `eth_rx_buffer_addr` only when the write happens.
    - Increment the 17-bit `word_cnt`.
    - When `word_cnt` reaches `rx_words`, go to DoRecv.
  - **DoRecv**: one write of CR with Sn_CR_RECV. On completion go to Finish.
  - **Finish** (1 cycle): `rx_done`=1, then Idle.
- Overflow handling: the FIFO is always fully drained even on overflow, so W5300 pointers stay consistent. Buffer contents hold the first 2^W words.
- An odd `rx_len` still reads a whole last word; the low byte is don't-care.
- `eth_rx_buffer_addr` restarts at 0 every pass. `rx_len` and `rx_overflow` hold their values until the next pass's CheckRxSize or ReadInfo.
- A new `eth_rx_req` arriving outside Idle is ignored.

## Timing
- Reset values:
  - State = Idle.
  - `addr`=`{RD,9'h000}`, `wr_data`=0.
  - `eth_rx_buffer_addr`=0, `eth_rx_buffer_data`=0, `eth_rx_buffer_wr`=0.
  - `rx_len`=0, `rx_overflow`=0, `rx_done`=0.
  - Internal `rx_size`=0, `word_cnt`=0.
- Reset mid-pass aborts immediately to Idle with the reset values above. No RECV is issued.
- `eth_rx_buffer_wr` and `rx_done` are registered. The buffer write appears the cycle after the `op_state` pulse that delivered the data, and is high for exactly one cycle.
- Minimum pass length with an empty socket: 1 (Idle→ReadRxSize) + 2 ops + 1 (Check) + 1 (Finish) cycles, plus bus latency.
- With zero bus wait (`op_state` high on the request's first cycle), each FIFOR read costs 1 cycle, giving one word per cycle.

## Test plan
- **Empty socket**: `eth_rx_req` pulse; RSR reads return 0x0000, 0x0000 → no FIFOR/CR access, `rx_len`=0, `rx_done` pulses once, no buffer writes.
- **Even packet**: RSR=0x0000_000A; info=0x0008; FIFOR data 0x1111, 0x2222, 0x3333, 0x4444 → 4 writes to addresses 0..3 with matching data, then a CR write of 0x0040, `rx_len`=8, `rx_done`.
- **Odd packet**: info=0x0005 → exactly 3 FIFOR reads and 3 writes, then RECV, `rx_len`=5.
- **Overflow with W=2**: info=0x000C → 6 FIFOR reads, only 4 writes (addresses 0..3), `rx_overflow`=1, RECV still issued.
- **Bus stalls**: `op_state` delayed 0..5 random cycles per operation → `addr`/`wr_data` stable throughout each operation, same results as above.
- **Reset mid-ReadFifoReg after 2 words**: `rst` high 1 cycle → all outputs at reset values next cycle, no CR write, and a subsequent `eth_rx_req` runs a clean pass.
